// File: rtl/jpeg_stream_arbiter_pkg.sv
// Shared types and constants for the JPEG stream arbiter.
// Optional stall watchdog is controlled by the JPEG_ARB_TIMEOUT_EN macro.
package jpeg_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_STREAM   = 2'd1,
        ARB_WAIT_END = 2'd2
    } arb_state_e;

    localparam int PIXELS_PER_BLOCK = 64;
    localparam int PIX_CNT_W        = 6;

    // Pixel count value of the final beat of an 8x8 block.
    localparam logic [PIX_CNT_W-1:0] PIX_CNT_LAST = 6'(PIXELS_PER_BLOCK - 1);

endpackage

// File: rtl/jpeg_stream_arbiter_if.sv
// Requester-side and encoder-side handshake bundle of the JPEG stream arbiter.
// master: the arbiter itself; slave: the requesters plus encoder environment.
interface jpeg_stream_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    enc_valid;
    logic [DATA_W-1:0]       enc_data;
    logic                    enc_last_block;
    logic                    enc_ready;
    logic                    enc_eof_done;

    modport master (
        input  req_valid, req_data, req_last, enc_ready, enc_eof_done,
        output req_ready, enc_valid, enc_data, enc_last_block
    );

    modport slave (
        output req_valid, req_data, req_last, enc_ready, enc_eof_done,
        input  req_ready, enc_valid, enc_data, enc_last_block
    );
endinterface

// File: rtl/jpeg_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module jpeg_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        int         cand;
        logic [W-1:0] cand_w;
        cand   = 0;
        cand_w = '0;
        idx    = '0;
        any    = |valid;
        for (int off = N - 1; off >= 0; off--) begin
            cand   = int'(ptr) + off;
            cand   = (cand >= N) ? cand - N : cand;
            cand_w = W'(cand);
            idx    = valid[cand_w] ? cand_w : idx;
        end
    end

endmodule

// File: rtl/jpeg_stream_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared JPEG encoder.
// Define JPEG_ARB_TIMEOUT_EN to add the stall watchdog and timeout_err output.
module jpeg_stream_arbiter
    import jpeg_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
`ifdef JPEG_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 4096,
`endif
    parameter int DATA_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    jpeg_stream_arbiter_if.master    bus,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
`ifdef JPEG_ARB_TIMEOUT_EN
    output logic                     timeout_err,
`endif
    output logic                     frame_done
);

    localparam int OW_W = $clog2(N_REQ);

    arb_state_e           state_q, state_d;
    logic [OW_W-1:0]      owner_q, owner_d;
    logic [OW_W-1:0]      rr_q, rr_d;
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic [OW_W-1:0]      pick_idx_s;
    logic                 pick_any_s;
    logic [OW_W-1:0]      next_rr_s;
    logic                 own_valid_s;
    logic                 own_last_s;
    logic [DATA_W-1:0]    own_data_s;
    logic                 xfer_s;
    logic                 enc_valid_s;
    logic [DATA_W-1:0]    enc_data_s;
    logic                 enc_last_s;
    logic [N_REQ-1:0]     req_ready_s;

`ifdef JPEG_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 timeout_q, timeout_d;
`endif

    jpeg_rr_pick #(
        .N (N_REQ),
        .W (OW_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_q),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    assign next_rr_s = (owner_q == OW_W'(N_REQ - 1)) ? '0 : owner_q + OW_W'(1);
    assign xfer_s    = (state_q == ARB_STREAM) && own_valid_s && bus.enc_ready;

    // Select the current owner's lane and steer the encoder's ready back to it only.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = '0;
        req_ready_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            own_valid_s    = (owner_q == OW_W'(i)) ? bus.req_valid[i] : own_valid_s;
            own_last_s     = (owner_q == OW_W'(i)) ? bus.req_last[i] : own_last_s;
            own_data_s     = (owner_q == OW_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : own_data_s;
            req_ready_s[i] = ((state_q == ARB_STREAM) && (owner_q == OW_W'(i))) ? bus.enc_ready : 1'b0;
        end
    end

    // Next-state and datapath control for the frame grant.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        enc_valid_s  = 1'b0;
        enc_data_s   = '0;
        enc_last_s   = 1'b0;
`ifdef JPEG_ARB_TIMEOUT_EN
        stall_d      = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    owner_d = pick_idx_s;
                    state_d = ARB_STREAM;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_STREAM: begin
                enc_valid_s = own_valid_s;
                enc_data_s  = own_data_s;
                // The block's last flag is only trusted on its first beat, then held.
                enc_last_s  = (cnt_q == '0) ? own_last_s : last_q;
                if (xfer_s) begin
                    cnt_d   = cnt_q + 6'd1;
                    last_d  = (cnt_q == '0) ? own_last_s : last_q;
                    state_d = ((cnt_q == PIX_CNT_LAST) && last_q) ? ARB_WAIT_END : ARB_STREAM;
                end else begin
`ifdef JPEG_ARB_TIMEOUT_EN
                    if (!own_valid_s && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1))) begin
                        timeout_d = 1'b1;
                        rr_d      = next_rr_s;
                        state_d   = ARB_IDLE;
                        cnt_d     = '0;
                        last_d    = 1'b0;
                        stall_d   = '0;
                    end else if (!own_valid_s) begin
                        stall_d = stall_q + STALL_W'(1);
                    end else begin
                        stall_d = stall_q;
                    end
`else
                    state_d = ARB_STREAM;
`endif
                end
            end
            ARB_WAIT_END: begin
                if (bus.enc_eof_done) begin
                    frame_done_d = 1'b1;
                    rr_d         = next_rr_s;
                    state_d      = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT_END;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ARB_IDLE);

    // State, grant and block-position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef JPEG_ARB_TIMEOUT_EN
    // Stall watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

    assign bus.enc_valid      = enc_valid_s;
    assign bus.enc_data       = enc_data_s;
    assign bus.enc_last_block = enc_last_s;
    assign bus.req_ready      = req_ready_s;
    assign owner              = owner_q;
    assign busy               = busy_q;
    assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_jpeg_stream_arbiter.sv
// Self-checking bench for jpeg_stream_arbiter: frame-level reference model with random data.
// Build with JPEG_ARB_TIMEOUT_EN defined to include the stall watchdog scenario.
module tb_jpeg_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BLK = 64;
`ifdef JPEG_ARB_TIMEOUT_EN
    localparam int TO  = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] owner;
    logic       busy;
    logic       frame_done;
`ifdef JPEG_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    jpeg_stream_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    jpeg_stream_arbiter #(
        .N_REQ          (N),
`ifdef JPEG_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES (TO),
`endif
        .DATA_W         (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .owner       (owner),
        .busy        (busy),
`ifdef JPEG_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Pending pixel words and block-last flags per requester.
    logic [DW-1:0] dq [N][$];
    bit            lq [N][$];

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-level view of who owns the encoder.
    int m_phase;      // 0 no grant, 1 streaming a frame, 2 waiting for end of bitstream
    int m_owner;
    int m_rr;
    int m_n;          // beats of the current frame already delivered
    int m_len;        // beats in the current frame
    int m_last_from;  // first beat index that belongs to the last block
    bit m_fd;
    bit m_to;
    int eof_wait;
`ifdef JPEG_ARB_TIMEOUT_EN
    int m_stall;
    int to_count;
`endif

    int hold_pct, ready_mode, stray_pct, stall_left, stall_req;
    bit tog, prev_busy;
    int dut_xfers, fd_count;
    int dut_grants[$];
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue_frame(input int r, input int nblocks);
        for (int b = 0; b < nblocks; b++) begin
            for (int p = 0; p < BLK; p++) begin
                dq[r].push_back($urandom);
                lq[r].push_back(b == nblocks - 1);
            end
        end
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (dq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic         rdy, eof;
        int           own, w;
        bit           found;
        check("busy", busy, 64'(m_phase != 0));
        check("owner", owner, 64'(m_owner));
        check("frame_done", frame_done, 64'(m_fd));
`ifdef JPEG_ARB_TIMEOUT_EN
        check("timeout_err", timeout_err, 64'(m_to));
        to_count += int'(timeout_err);
`endif
        if (busy && !prev_busy) dut_grants.push_back(int'(owner));
        prev_busy = busy;
        fd_count += int'(frame_done);

        v = '0;
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0 && !(stall_left > 0 && stall_req == i) &&
                $urandom_range(99) >= 32'(hold_pct)) v[i] = 1'b1;
            if (v[i]) bus.req_data[i*DW +: DW] = dq[i][0];
            else      bus.req_data[i*DW +: DW] = '0;
            if (dq[i].size() > 0) bus.req_last[i] = lq[i][0];
            else                  bus.req_last[i] = 1'b0;
        end
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = tog;
            default: rdy = 1'($urandom_range(1));
        endcase
        eof = (m_phase == 2 && eof_wait == 0) || (m_phase == 1 && $urandom_range(99) < 32'(stray_pct));
        bus.req_valid    = v;
        bus.enc_ready    = rdy;
        bus.enc_eof_done = eof;
        #3;

        own     = m_owner;
        exp_rdy = '0;
        if (m_phase == 1) exp_rdy[own] = rdy;
        check("enc_valid", bus.enc_valid, 64'((m_phase == 1) && v[own]));
        check("req_ready", bus.req_ready, 64'(exp_rdy));
        if (m_phase == 1 && v[own]) begin
            check("enc_data", bus.enc_data, 64'(dq[own][0]));
            check("enc_last_block", bus.enc_last_block, 64'(m_n >= m_last_from));
        end
        if (bus.enc_valid && bus.enc_ready) dut_xfers++;

        m_fd = 1'b0;
        m_to = 1'b0;
        if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                w = (m_rr + k) % N;
                if (!found && v[w]) begin
                    found   = 1'b1;
                    m_owner = w;
                end
            end
            if (found) begin
                m_phase     = 1;
                m_n         = 0;
                m_last_from = 0;
                while (m_last_from < lq[m_owner].size() && !lq[m_owner][m_last_from]) m_last_from++;
                m_len = m_last_from + BLK;
`ifdef JPEG_ARB_TIMEOUT_EN
                m_stall = 0;
`endif
            end
        end else if (m_phase == 1) begin
            if (v[own] && rdy) begin
                void'(dq[own].pop_front());
                void'(lq[own].pop_front());
                m_n++;
`ifdef JPEG_ARB_TIMEOUT_EN
                m_stall = 0;
`endif
                if (m_n == m_len) begin
                    m_phase  = 2;
                    eof_wait = int'($urandom_range(3));
                end
            end else if (!v[own]) begin
`ifdef JPEG_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_to    = 1'b1;
                    m_phase = 0;
                    m_rr    = (own + 1) % N;
                    repeat (m_len - m_n) begin
                        void'(dq[own].pop_front());
                        void'(lq[own].pop_front());
                    end
                end
`endif
            end
        end else begin
            if (eof) begin
                m_fd    = 1'b1;
                m_phase = 0;
                m_rr    = (own + 1) % N;
            end else begin
                eof_wait--;
            end
        end
        if (stall_left > 0) stall_left--;
        tog = ~tog;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(m_phase == 0 && !m_fd && queues_empty()) && n < budget);
        check("drain_budget", 64'(n < budget), 64'(1));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check("rst_busy", busy, 64'(0));
        check("rst_owner", owner, 64'(0));
        check("rst_frame_done", frame_done, 64'(0));
        check("rst_enc_valid", bus.enc_valid, 64'(0));
        check("rst_enc_data", bus.enc_data, 64'(0));
        check("rst_enc_last", bus.enc_last_block, 64'(0));
        check("rst_req_ready", bus.req_ready, 64'(0));
`ifdef JPEG_ARB_TIMEOUT_EN
        check("rst_timeout_err", timeout_err, 64'(0));
`endif
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            lq[i].delete();
        end
        bus.req_valid    = '0;
        bus.req_last     = '0;
        bus.enc_eof_done = 1'b0;
        m_phase    = 0;
        m_owner    = 0;
        m_rr       = 0;
        m_fd       = 1'b0;
        m_to       = 1'b0;
        prev_busy  = 1'b0;
        stall_left = 0;
        rst        = 1'b0;
    endtask

    initial begin
        int guard;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.enc_ready    = 1'b0;
        bus.enc_eof_done = 1'b0;
        hold_pct = 0; ready_mode = 0; stray_pct = 0; stall_left = 0; stall_req = 0;
        tog = 1'b0; dut_xfers = 0; fd_count = 0; eof_wait = 0;
`ifdef JPEG_ARB_TIMEOUT_EN
        to_count = 0;
`endif
        do_reset(3);

        // Single two-block frame from requester 0 at full rate.
        enqueue_frame(0, 2);
        dut_xfers = 0;
        fd_count  = 0;
        run_idle(400);
        check("t2_xfers", 64'(dut_xfers), 64'(128));
        check("t2_frame_done_count", 64'(fd_count), 64'(1));

        // Reset in the middle of a frame.
        enqueue_frame(1, 2);
        repeat (30) cycle();
        do_reset(3);

        // Round robin across all requesters, requester 0 queues a second frame.
        for (int r = 0; r < N; r++) enqueue_frame(r, 1);
        enqueue_frame(0, 1);
        dut_grants.delete();
        run_idle(1500);
        check("t3_grant_count", 64'(dut_grants.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < dut_grants.size()) check("t3_grant_order", 64'(dut_grants[k]), 64'(exp_rr[k]));
        end

        // Toggling encoder backpressure plus a 10-cycle owner stall mid-block.
        ready_mode = 1;
        enqueue_frame(0, 2);
        dut_xfers = 0;
        dut_grants.delete();
        repeat (40) cycle();
        stall_req  = 0;
        stall_left = 10;
        run_idle(800);
        check("t4_xfers", 64'(dut_xfers), 64'(128));
        check("t4_grant_held", 64'(dut_grants.size()), 64'(1));

        // End of bitstream coinciding with a new request, stray eof pulses while streaming.
        ready_mode = 0;
        stray_pct  = 30;
        enqueue_frame(1, 1);
        guard = 0;
        while (!(m_phase == 2 && eof_wait == 0) && guard < 300) begin
            cycle();
            guard++;
        end
        check("t5_reach_wait_end", 64'(guard < 300), 64'(1));
        stray_pct = 0;
        enqueue_frame(2, 1);
        dut_grants.delete();
        fd_count = 0;
        repeat (3) cycle();
        check("t5_frame_done_count", 64'(fd_count), 64'(1));
        check("t5_new_owner", 64'((dut_grants.size() == 1) ? dut_grants[0] : -1), 64'(2));
        run_idle(400);

        // Randomised traffic: idle requesters, random readiness, occasional stray eof.
        hold_pct   = 15;
        ready_mode = 2;
        stray_pct  = 5;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1) == 1) enqueue_frame(i, 1 + int'($urandom_range(1)));
            end
            enqueue_frame(int'($urandom_range(N - 1)), 1);
            run_idle(6000);
        end

`ifdef JPEG_ARB_TIMEOUT_EN
        // Owner abandons its frame after 10 beats; watchdog hands the encoder on.
        do_reset(3);
        hold_pct = 0; ready_mode = 0; stray_pct = 0;
        enqueue_frame(0, 1);
        enqueue_frame(1, 1);
        dut_grants.delete();
        fd_count = 0;
        to_count = 0;
        guard    = 0;
        while (!(m_phase == 1 && m_n == 10) && guard < 100) begin
            cycle();
            guard++;
        end
        stall_req  = 0;
        stall_left = 200;
        run_idle(500);
        check("t6_timeout_count", 64'(to_count), 64'(1));
        check("t6_frame_done_count", 64'(fd_count), 64'(1));
        check("t6_grant_count", 64'(dut_grants.size()), 64'(2));
        if (dut_grants.size() == 2) check("t6_next_owner", 64'(dut_grants[1]), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
